// File: rtl/sr_window_ctrl_pkg.sv
// Shared definitions for the window-buffer sequencer: FSM encodings and
// the counter-width helper used for column/row counters and window coordinates.
package sr_window_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COL    = 2'd1,
        ST_ROW_UP = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit so a degenerate
    // single-pixel dimension still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sr_window_ctrl_wrap_counter.sv
// Up-counter over 0..MAX with synchronous clear and a terminal-count flag.
// Used for both the column and row position of the raster scan.
module wrap_counter
    import sr_window_ctrl_pkg::*;
#(
    parameter int MAX   = 15,
    parameter int WIDTH = cnt_width(MAX + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    assign at_max = (count == WIDTH'(MAX));

    // Clear has priority; an enabled step at MAX wraps back to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_max ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sr_window_ctrl.sv
// Sequencer for a KERNEL-row shift-register window buffer. Accepts a raster
// pixel stream, steps the array (shift along a row, then one row-up shift at
// each row end) and presents each complete window's top-left coordinates to
// the MAC stage. The array is frozen while a window is waiting to be consumed.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for start; counters cleared on start
//   ST_COL    | accepting pixels along the current row
//   ST_ROW_UP | one-cycle row-up shift of the array before the next row
//   ST_DRAIN  | frame scanned; wait for the last window to be consumed
module sr_window_ctrl
    import sr_window_ctrl_pkg::*;
#(
    parameter  int IMG_WIDTH  = 16,
    parameter  int IMG_HEIGHT = 16,
    parameter  int KERNEL     = 3,
    localparam int COL_W      = cnt_width(IMG_WIDTH),
    localparam int ROW_W      = cnt_width(IMG_HEIGHT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    input  logic             window_ready,
    output logic             sr_enable,
    output logic             sr_shift_row_up,
    output logic             window_valid,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             busy,
    output logic             done
);

    localparam int KM1 = KERNEL - 1;

    state_t state;
    state_t state_next;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;
    logic             row_last;
    logic             col_en;
    logic             col_clr;
    logic             row_en;
    logic             row_clr;
    logic             stall;
    logic             accept;
    logic             done_set;
    logic             win_hit;

    wrap_counter #(.MAX(IMG_WIDTH - 1), .WIDTH(COL_W)) u_col_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (col_en),
        .clear  (col_clr),
        .count  (col),
        .at_max (col_last)
    );

    wrap_counter #(.MAX(IMG_HEIGHT - 1), .WIDTH(ROW_W)) u_row_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (row_en),
        .clear  (row_clr),
        .count  (row),
        .at_max (row_last)
    );

    // An unconsumed window freezes the array; this is the only route from
    // window_ready into the array controls.
    assign stall = window_valid & ~window_ready;

    // A window is complete once KERNEL columns and KERNEL rows have been seen.
    assign win_hit = accept && (int'(col) >= KM1) && (int'(row) >= KM1);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and array controls; sr_enable follows accept in the same
    // cycle so the pixel lands in the array on the accepting edge.
    always_comb begin
        state_next      = state;
        pixel_ready     = 1'b0;
        sr_enable       = 1'b0;
        sr_shift_row_up = 1'b0;
        col_en          = 1'b0;
        col_clr         = 1'b0;
        row_en          = 1'b0;
        row_clr         = 1'b0;
        done_set        = 1'b0;
        accept          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    col_clr    = 1'b1;
                    row_clr    = 1'b1;
                    state_next = ST_COL;
                end
            end
            ST_COL: begin
                pixel_ready = ~stall;
                if (pixel_valid && !stall) begin
                    accept    = 1'b1;
                    sr_enable = 1'b1;
                    col_en    = 1'b1;
                    if (col_last) begin
                        state_next = row_last ? ST_DRAIN : ST_ROW_UP;
                    end
                end
            end
            ST_ROW_UP: begin
                if (!stall) begin
                    sr_enable       = 1'b1;
                    sr_shift_row_up = 1'b1;
                    row_en          = 1'b1;
                    state_next      = ST_COL;
                end
            end
            ST_DRAIN: begin
                if (!window_valid || window_ready) begin
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered status outputs and window tracking; a new window on the same
    // edge as a consume keeps window_valid high with the new coordinates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            window_valid <= 1'b0;
            win_col      <= '0;
            win_row      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= done_set;
            busy <= (state_next != ST_IDLE);
            if (win_hit) begin
                window_valid <= 1'b1;
                win_col      <= col - COL_W'(KM1);
                win_row      <= row - ROW_W'(KM1);
            end else if (window_ready) begin
                window_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sr_window_ctrl.sv
// Bench for sr_window_ctrl on a 4x4 image with a 3x3 kernel. Stimulus pushes
// the expected window coordinates; a negedge monitor pops and compares them on
// each consumed window and keeps event counters used for per-frame totals.
module tb_sr_window_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int K = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       window_ready = 1'b0;
    logic       pixel_ready;
    logic       sr_enable;
    logic       sr_shift_row_up;
    logic       window_valid;
    logic [1:0] win_col;
    logic [1:0] win_row;
    logic       busy;
    logic       done;

    sr_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .window_ready    (window_ready),
        .sr_enable       (sr_enable),
        .sr_shift_row_up (sr_shift_row_up),
        .window_valid    (window_valid),
        .win_col         (win_col),
        .win_row         (win_row),
        .busy            (busy),
        .done            (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int c;
        int r;
    } win_t;

    win_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   shift_cnt = 0;
    int   done_cnt = 0;
    int   pop_cnt  = 0;
    int   done_cyc = 0;
    int   s_acc, s_shift, s_done, s_pop;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: event counters plus scoreboard compare on each consumed window.
    always @(negedge clock) begin
        if (reset) begin
            if (pixel_valid && pixel_ready) acc_cnt++;
            if (sr_shift_row_up) shift_cnt++;
            if (done) done_cnt++;
            if (window_valid && window_ready) begin
                pop_cnt++;
                check("window_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    win_t e;
                    e = exp_q.pop_front();
                    check("win_col", int'(win_col), e.c);
                    check("win_row", int'(win_row), e.r);
                end
            end
        end
    end

    task automatic snapshot_and_push();
        s_acc   = acc_cnt;
        s_shift = shift_cnt;
        s_done  = done_cnt;
        s_pop   = pop_cnt;
        for (int r = 0; r <= H - K; r++) begin
            for (int c = 0; c <= W - K; c++) begin
                exp_q.push_back('{c: c, r: r});
            end
        end
    endtask

    task automatic begin_frame();
        snapshot_and_push();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        int i;
        i = 0;
        @(negedge clock);
        while (!done && i < 300) begin
            @(negedge clock);
            i++;
        end
        done_cyc = cyc;
        check({tag, "_done_seen"}, int'(done), 1);
        @(negedge clock);
        check({tag, "_done_width"}, int'(done), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_accepts"}, acc_cnt - s_acc, W * H);
        check({tag, "_row_up_pulses"}, shift_cnt - s_shift, H - 1);
        check({tag, "_done_pulses"}, done_cnt - s_done, 1);
        check({tag, "_windows"}, pop_cnt - s_pop, (W - K + 1) * (H - K + 1));
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel_ready"}, int'(pixel_ready), 0);
        check({tag, "_sr_enable"}, int'(sr_enable), 0);
        check({tag, "_shift_row_up"}, int'(sr_shift_row_up), 0);
        check({tag, "_window_valid"}, int'(window_valid), 0);
        check({tag, "_win_col"}, int'(win_col), 0);
        check({tag, "_win_row"}, int'(win_row), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int i;
        int t0;
        int pat[4];
        pat = '{1, 0, 0, 1};

        // Reset state.
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check_all_zero("reset");

        // Abort mid-frame at col=2,row=1: six accepts, then reset.
        pixel_valid  = 1'b1;
        window_ready = 1'b1;
        s_done = done_cnt;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        n = 0;
        i = 0;
        while (n < 6 && i < 50) begin
            @(negedge clock);
            if (pixel_valid && pixel_ready) n++;
            i++;
        end
        check("abort_accepts", n, 6);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_all_zero("in_reset");
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check_all_zero("after_reset");
        repeat (4) @(negedge clock);
        check("abort_no_done", done_cnt - s_done, 0);
        check("abort_idle_busy", int'(busy), 0);

        // Full frame, free-flowing; first accept to done is 16+3+1 cycles.
        pixel_valid  = 1'b1;
        window_ready = 1'b1;
        begin_frame();
        i = 0;
        @(negedge clock);
        while (!(pixel_valid && pixel_ready) && i < 20) begin
            @(negedge clock);
            i++;
        end
        t0 = cyc;
        finish_frame("full");
        check("full_latency", done_cyc - t0, W * H + (H - 1) + 1);

        // Backpressure at the first window for 5 cycles.
        window_ready = 1'b0;
        begin_frame();
        i = 0;
        @(negedge clock);
        while (!window_valid && i < 40) begin
            @(negedge clock);
            i++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_window_valid", int'(window_valid), 1);
            check("bp_win_col", int'(win_col), 0);
            check("bp_win_row", int'(win_row), 0);
            check("bp_pixel_ready", int'(pixel_ready), 0);
            check("bp_sr_enable", int'(sr_enable), 0);
            if (k < 4) @(negedge clock);
        end
        @(posedge clock); #1 window_ready = 1'b1;
        @(negedge clock);
        check("bp_resume_ready", int'(pixel_ready), 1);
        check("bp_resume_enable", int'(sr_enable), 1);
        finish_frame("bp");

        // Stall across the row-up after the last pixel of row 2.
        window_ready = 1'b1;
        begin_frame();
        n = 0;
        i = 0;
        while (n < 12 && i < 60) begin
            @(negedge clock);
            if (pixel_valid && pixel_ready) n++;
            i++;
        end
        check("rs_accepts", n, 12);
        @(posedge clock); #1 window_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rs_hold_shift", int'(sr_shift_row_up), 0);
            check("rs_hold_enable", int'(sr_enable), 0);
            check("rs_hold_valid", int'(window_valid), 1);
        end
        @(posedge clock); #1 window_ready = 1'b1;
        @(negedge clock);
        check("rs_release_shift", int'(sr_shift_row_up), 1);
        check("rs_release_col", int'(win_col), 1);
        check("rs_release_row", int'(win_row), 0);
        @(negedge clock);
        check("rs_single_pulse", int'(sr_shift_row_up), 0);
        finish_frame("rs");

        // Upstream gaps 1,0,0,1 with start held high mid-frame (ignored).
        snapshot_and_push();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pixel_valid = (pat[k] != 0);
            start = (k >= 1);
            @(negedge clock);
            check("gap_sr_enable", int'(sr_enable), pat[k]);
            check("gap_busy", int'(busy), 1);
            @(posedge clock); #1;
        end
        start = 1'b0;
        pixel_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("gap_fill_enable", int'(sr_enable), 1);
            check("gap_fill_shift", int'(sr_shift_row_up), 0);
        end
        @(negedge clock);
        check("gap_row_end_shift", int'(sr_shift_row_up), 1);
        finish_frame("gap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_window_ctrl.md
Name: sr_window_ctrl

Overview:
- Sequencer for a KERNEL-row array of parallel-out shift registers that forms the convolution window buffer.
- Accepts a raster pixel stream through a valid/ready handshake and drives the array's enable and shift_row_up controls.
- Flags each cycle the array holds a complete KERNEL x KERNEL window and reports that window's coordinates to the downstream MAC stage, with backpressure.

Parameters:
- IMG_WIDTH, 16, pixels per image row (>= KERNEL)
- IMG_HEIGHT, 16, rows per image (>= KERNEL)
- KERNEL, 3, window side length (>= 1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a frame; honoured only in IDLE
- pixel_valid  in  1  upstream pixel present
- pixel_ready  out  1  controller accepts pixel this cycle
- window_ready  in  1  downstream consumed current window
- sr_enable  out  1  to array enable
- sr_shift_row_up  out  1  to array shift_row_up
- window_valid  out  1  array holds a complete window
- win_col  out  $clog2(IMG_WIDTH)  top-left column of the valid window
- win_row  out  $clog2(IMG_HEIGHT)  top-left row of the valid window
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (asynchronous, active-low) gives state IDLE, counters 0, window_valid=0, win_col/win_row=0, done=0. All outputs read 0. Reset mid-frame abandons the frame, and no done pulse is issued.
- States:
  - IDLE: start goes to COL with col=row=0; busy=0.
  - COL: pixel_ready = !stall, where stall = window_valid & !window_ready. Accept = pixel_valid & pixel_ready. On accept, sr_enable=1 and sr_shift_row_up=0, combinationally in the same cycle, so pixel data meets the array edge. On accept with col<IMG_WIDTH-1: col++. On accept with col==IMG_WIDTH-1: col=0. Then if row<IMG_HEIGHT-1 go to ROW_UP, else go to DRAIN.
  - ROW_UP: pixel_ready=0. When !stall: sr_enable=1, sr_shift_row_up=1 for exactly one cycle, row++, go to COL. While stalled, both sr outputs stay 0 and the state holds.
  - DRAIN: pixel_ready=0. Wait until !window_valid, or until window_valid & window_ready. Then go to IDLE with done=1 registered for one cycle.
- busy=1 in every state except IDLE. start outside IDLE is ignored.
- Window generation:
  - An accept at (col,row) with col>=KERNEL-1 and row>=KERNEL-1 sets window_valid=1 on the next edge.
  - The same edge sets win_col=col-(KERNEL-1) and win_row=row-(KERNEL-1). Latency is 1 cycle after accept.
  - window_valid clears on window_ready unless a new window is set on the same edge; set wins.
  - win_col/win_row hold until the next window.
- The stall rule guarantees the array never shifts while an unconsumed window is presented.
- Windows per frame: (IMG_WIDTH-KERNEL+1)*(IMG_HEIGHT-KERNEL+1). sr_shift_row_up pulses per frame: IMG_HEIGHT-1.
- KERNEL==1: every accepted pixel yields a window.
- col and row are wrap-free: they never exceed IMG_WIDTH-1 and IMG_HEIGHT-1.
- No combinational path from window_ready to sr_shift_row_up other than through stall. All control outputs except pixel_ready/sr_enable/sr_shift_row_up are registered.

Decomposition:
- Shared package/include holds the state encodings (IDLE, COL, ROW_UP, DRAIN) and the width-function macros for the counter widths.
- One sub-module is natural: wrap_counter (enable, clear, terminal-count flag, parameterised MAX). It is instantiated twice, for col and row.

Test Plan:
- Reset: assert reset mid-COL at col=2,row=1, deassert -> all outputs 0, state IDLE, next start restarts at (0,0), no done pulse.
- Full frame, 4x4, KERNEL=3, pixel_valid=1, window_ready=1 -> 16 accepts, 3 sr_shift_row_up pulses, 4 window_valid pulses with (win_col,win_row)=(0,0),(1,0),(0,1),(1,1), done 1 cycle, 16+3+1 cycles from first accept to done.
- Backpressure: hold window_ready=0 for 5 cycles at first window -> window_valid held with (0,0), pixel_ready=0, sr_enable=0 throughout; resumes accepting on the cycle window_ready=1.
- Stall at row end: window_ready=0 when last pixel of row 2 accepted -> ROW_UP waits with sr_shift_row_up=0, issues exactly one pulse after release.
- Upstream gaps: pixel_valid toggling 1,0,0,1 -> sr_enable high only on valid cycles, col advances by 2.
- start during busy -> ignored, counters unaffected.
